// File: rtl/multi_channel_rom_reader.sv
// multi_channel_rom_reader: N client channels share one dual-port coefficient ROM.
// A round-robin arbiter issues up to two reads per cycle (port A, port B); a tag
// pipeline tracks {valid, channel} per port and steers each word back to its requester.
module multi_channel_rom_reader #(
  parameter int              Width        = 16,
  parameter int              Depth        = 1024,
  parameter int              NumChannels  = 4,
  parameter int              ReadLatency  = 2,   // 1 or 2
  parameter logic [8*16-1:0] DeviceFamily = "Cyclone V",
  parameter logic [8*16-1:0] RamBlockType = "M10K",
  parameter logic [8*32-1:0] MIF_File     = "ROM.mif",
  localparam int AddressWidth = $clog2(Depth),
  localparam int ChW          = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                                ipClk,
  input  logic                                ipReset,
  input  logic [NumChannels-1:0]              ipValid,
  input  logic [NumChannels*AddressWidth-1:0] ipAddress,
  output logic [NumChannels-1:0]              opReady,
  output logic [NumChannels-1:0]              opValid,
  output logic [NumChannels*Width-1:0]        opData
);

  // Behavioural stand-in for the MIF image: word a = {~a[7:0], a[7:0]}, word 5 = 0xBEEF.
  function automatic logic [Width-1:0] rom_word(input logic [AddressWidth-1:0] a);
    logic [7:0]  lo;
    logic [15:0] w;
    lo = 8'(a);
    w  = {~lo, lo};
    if (a == AddressWidth'(5)) w = 16'hBEEF;
    return Width'(w);
  endfunction

  // Primitive attributes only matter to the vendor RAM; keep them referenced.
  logic unused_params;
  assign unused_params = ^{DeviceFamily, RamBlockType, MIF_File};

  logic [NumChannels-1:0][AddressWidth-1:0] addr_v;
  assign addr_v = ipAddress;

  logic [ChW-1:0]          ptr_q, ptr_nxt, last_ch, scan_idx;
  logic                    gnt_vld  [2];
  logic [ChW-1:0]          gnt_ch   [2];
  logic [AddressWidth-1:0] gnt_addr [2];
  logic                    tag_vld  [2];
  logic [ChW-1:0]          tag_ch   [2];
  logic [Width-1:0]        rom_q    [2];

  // Round-robin scan from ptr_q: first valid channel -> port A, second -> port B
  always_comb begin
    gnt_vld[0]  = 1'b0;
    gnt_vld[1]  = 1'b0;
    gnt_ch[0]   = '0;
    gnt_ch[1]   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NumChannels; k++) begin
      scan_idx = ChW'((int'(ptr_q) + k) % NumChannels);
      if (ipValid[scan_idx] && !ipReset) begin
        if (!gnt_vld[0]) begin
          gnt_vld[0] = 1'b1;
          gnt_ch[0]  = scan_idx;
        end else if (!gnt_vld[1]) begin
          gnt_vld[1] = 1'b1;
          gnt_ch[1]  = scan_idx;
        end
      end
    end
    // Idle ports present address 0 (port B always idle with a single channel)
    gnt_addr[0] = gnt_vld[0] ? addr_v[gnt_ch[0]] : '0;
    gnt_addr[1] = gnt_vld[1] ? addr_v[gnt_ch[1]] : '0;
  end

  assign last_ch = gnt_vld[1] ? gnt_ch[1] : gnt_ch[0];
  assign ptr_nxt = (last_ch == ChW'(NumChannels - 1)) ? '0 : last_ch + 1'b1;

  // Pointer moves past the last granted channel; holds when nothing is granted
  always_ff @(posedge ipClk) begin
    if (ipReset)         ptr_q <= '0;
    else if (gnt_vld[0]) ptr_q <= ptr_nxt;
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [AddressWidth-1:0]         addr_q;
    logic [Width-1:0]                q_q;
    logic [ReadLatency-1:0]          vld_pipe;
    logic [ReadLatency-1:0][ChW-1:0] ch_pipe;

    // ROM port: optional address register, then registered read (q lands with the last tag stage)
    always_ff @(posedge ipClk) begin
      addr_q <= gnt_addr[p];
      q_q    <= rom_word((ReadLatency == 1) ? gnt_addr[p] : addr_q);
    end

    // Tag shift register; reset drops every in-flight read
    always_ff @(posedge ipClk) begin
      if (ipReset) begin
        vld_pipe <= '0;
      end else begin
        for (int s = ReadLatency - 1; s > 0; s--) vld_pipe[s] <= vld_pipe[s-1];
        vld_pipe[0] <= gnt_vld[p];
      end
      for (int s = ReadLatency - 1; s > 0; s--) ch_pipe[s] <= ch_pipe[s-1];
      ch_pipe[0] <= gnt_ch[p];
    end

    assign tag_vld[p] = vld_pipe[ReadLatency-1];
    assign tag_ch[p]  = ch_pipe[ReadLatency-1];
    assign rom_q[p]   = q_q;
  end

  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    logic             hit_a, hit_b;
    logic [Width-1:0] data_q, data_nxt;

    assign opReady[c] = (gnt_vld[0] && gnt_ch[0] == ChW'(c)) ||
                        (gnt_vld[1] && gnt_ch[1] == ChW'(c));
    // Ports never carry the same channel together, so at most one hit per channel
    assign hit_a      = tag_vld[0] && tag_ch[0] == ChW'(c) && !ipReset;
    assign hit_b      = tag_vld[1] && tag_ch[1] == ChW'(c) && !ipReset;
    assign opValid[c] = hit_a || hit_b;
    assign data_nxt   = hit_a ? rom_q[0] : (hit_b ? rom_q[1] : data_q);
    assign opData[c*Width +: Width] = data_nxt;

    // Hold the last response word between responses
    always_ff @(posedge ipClk) begin
      if (ipReset) data_q <= '0;
      else         data_q <= data_nxt;
    end
  end

endmodule
